// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit add/sub rippled through STAGES register slices with valid/ready handshake
module pipelined_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;
  logic [STAGES-1:0] v_q, v_d, adv, c_q, c_d;
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic ovf_q, ovf_d;
  logic [WIDTH-1:0] sa, sb, ss;
  logic sc;
  always_comb begin
    adv[STAGES-1] = !v_q[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) adv[i] = !v_q[i] || adv[i+1];
    ovf_d = ovf_q;
    sa = '0;
    sb = '0;
    ss = '0;
    sc = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      sa = i == 0 ? a : a_q[i == 0 ? 0 : i - 1];
      sb = i == 0 ? (sub ? ~b : b) : b_q[i == 0 ? 0 : i - 1];
      ss = i == 0 ? '0 : s_q[i == 0 ? 0 : i - 1];
      sc = i == 0 ? (sub | cin) : c_q[i == 0 ? 0 : i - 1];
      for (int j = 0; j < CHUNK; j++) begin
        ss[i*CHUNK+j] = sa[i*CHUNK+j] ^ sb[i*CHUNK+j] ^ sc;
        sc = (sa[i*CHUNK+j] & sb[i*CHUNK+j]) | (sc & (sa[i*CHUNK+j] ^ sb[i*CHUNK+j]));
      end
      v_d[i] = adv[i] ? (i == 0 ? in_valid : v_q[i == 0 ? 0 : i - 1]) : v_q[i];
      a_d[i] = adv[i] ? sa : a_q[i];
      b_d[i] = adv[i] ? sb : b_q[i];
      s_d[i] = adv[i] ? ss : s_q[i];
      c_d[i] = adv[i] ? sc : c_q[i];
      if (i == STAGES - 1 && adv[i]) ovf_d = (sa[MSB] == sb[MSB]) && (ss[MSB] != sa[MSB]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        s_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      ovf_q <= ovf_d;
      for (int i = 0; i < STAGES; i++) begin
        a_q[i] <= a_d[i];
        b_q[i] <= b_d[i];
        s_q[i] <= s_d[i];
      end
    end
  end
  assign in_ready = adv[0];
  assign out_valid = v_q[STAGES-1];
  assign sum = s_q[STAGES-1];
  assign cout = c_q[STAGES-1];
  assign ovf = ovf_q;
endmodule
